// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for pong: detects goals from ball x, keeps scores,
// times serve/point holds in frame ticks and handles pause and game over.
module pong_match_ctrl #(
  parameter int X_POS_W     = 11,
  parameter int LEFT_GOAL   = 4,
  parameter int RIGHT_GOAL  = 636,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int TICK_CNT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               run_o,
  output logic               ball_reset_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_player_o,
  output logic [SCORE_W-1:0] score_pc_o,
  output logic [2:0]         state_o,
  output logic               game_over_o,
  output logic               winner_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_PAUSE     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam logic [SCORE_W-1:0]    WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [TICK_CNT_W-1:0] SERVE_LAST = TICK_CNT_W'(SERVE_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] POINT_LAST = TICK_CNT_W'(POINT_TICKS - 1);
  localparam logic [X_POS_W-1:0]    LEFT_X     = X_POS_W'(LEFT_GOAL);
  localparam logic [X_POS_W-1:0]    RIGHT_X    = X_POS_W'(RIGHT_GOAL);

  logic [2:0]            state_q, state_d;
  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0]    score_player_q, score_player_d;
  logic [SCORE_W-1:0]    score_pc_q, score_pc_d;
  logic                  run_q, run_d;
  logic                  ball_reset_q, ball_reset_d;
  logic                  serve_dir_q, serve_dir_d;
  logic                  winner_q, winner_d;
  logic                  start_q, start_d, pause_q, pause_d;
  logic                  start_arm_q, start_arm_d, pause_arm_q, pause_arm_d;

  logic start_edge, pause_edge, goal_left, goal_right;

  // A key only arms after it has been seen released, so a key held
  // through reset cannot fire as soon as reset lifts.
  assign start_edge  = start_i & ~start_q & start_arm_q;
  assign pause_edge  = pause_i & ~pause_q & pause_arm_q;
  assign start_d     = start_i;
  assign pause_d     = pause_i;
  assign start_arm_d = start_arm_q | ~start_i;
  assign pause_arm_d = pause_arm_q | ~pause_i;

  assign goal_left  = (ball_x_i < LEFT_X);
  assign goal_right = (ball_x_i > RIGHT_X);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    score_player_d = score_player_q;
    score_pc_d     = score_pc_q;
    serve_dir_d    = serve_dir_q;
    winner_d       = winner_q;
    ball_reset_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          state_d        = ST_SERVE;
          cnt_d          = '0;
          score_player_d = '0;
          score_pc_d     = '0;
          serve_dir_d    = 1'b1;
          ball_reset_d   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick_i) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // Left goal beats right goal, and any goal beats a pause press.
        if (goal_left) begin
          score_player_d = (score_player_q == WIN) ? WIN : score_player_q + SCORE_W'(1);
          serve_dir_d    = 1'b0;
          state_d        = ST_POINT;
          cnt_d          = '0;
        end else if (goal_right) begin
          score_pc_d  = (score_pc_q == WIN) ? WIN : score_pc_q + SCORE_W'(1);
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
          cnt_d       = '0;
        end else if (pause_edge) begin
          state_d = ST_PAUSE;
          cnt_d   = '0;
        end
      end
      ST_POINT: begin
        if (tick_i) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if ((score_player_q == WIN) || (score_pc_q == WIN)) begin
              state_d  = ST_GAME_OVER;
              winner_d = (score_player_q == WIN);
            end else begin
              state_d      = ST_SERVE;
              ball_reset_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + TICK_CNT_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (pause_edge) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // run_o is decoded from the next state so it is high exactly while PLAY is held.
  assign run_d = (state_d == ST_PLAY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      score_player_q <= '0;
      score_pc_q     <= '0;
      run_q          <= 1'b0;
      ball_reset_q   <= 1'b0;
      serve_dir_q    <= 1'b1;
      winner_q       <= 1'b0;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
      start_arm_q    <= 1'b0;
      pause_arm_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_player_q <= score_player_d;
      score_pc_q     <= score_pc_d;
      run_q          <= run_d;
      ball_reset_q   <= ball_reset_d;
      serve_dir_q    <= serve_dir_d;
      winner_q       <= winner_d;
      start_q        <= start_d;
      pause_q        <= pause_d;
      start_arm_q    <= start_arm_d;
      pause_arm_q    <= pause_arm_d;
    end
  end

  assign run_o          = run_q;
  assign ball_reset_o   = ball_reset_q;
  assign serve_dir_o    = serve_dir_q;
  assign score_player_o = score_player_q;
  assign score_pc_o     = score_pc_q;
  assign state_o        = state_q;
  assign game_over_o    = (state_q == ST_GAME_OVER);
  assign winner_o       = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a rule-level match model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pong_match_ctrl;

  localparam int SERVE_T = 60;
  localparam int POINT_T = 90;
  localparam int WIN     = 7;

  logic        clk_i    = 1'b0;
  logic        rst_ni   = 1'b0;
  logic        tick_i   = 1'b0;
  logic        start_i  = 1'b0;
  logic        pause_i  = 1'b0;
  logic [10:0] ball_x_i = 11'd320;
  logic        run_o, ball_reset_o, serve_dir_o, game_over_o, winner_o;
  logic [3:0]  score_player_o, score_pc_o;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pong_match_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tick_i         (tick_i),
    .start_i        (start_i),
    .pause_i        (pause_i),
    .ball_x_i       (ball_x_i),
    .run_o          (run_o),
    .ball_reset_o   (ball_reset_o),
    .serve_dir_o    (serve_dir_o),
    .score_player_o (score_player_o),
    .score_pc_o     (score_pc_o),
    .state_o        (state_o),
    .game_over_o    (game_over_o),
    .winner_o       (winner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: phase names follow the display encoding, holds count down ticks left.
  int m_state = 0, m_pl = 0, m_pc = 0, m_left = 0;
  bit m_dir = 1, m_win = 0, m_breset = 0;
  bit m_sprev = 0, m_pprev = 0, m_sok = 0, m_pok = 0;
  bit s_edge, p_edge, g_left, g_right;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_state = 0; m_pl = 0; m_pc = 0; m_left = 0;
      m_dir = 1; m_win = 0; m_breset = 0;
      m_sprev = 0; m_pprev = 0; m_sok = 0; m_pok = 0;
    end else begin
      s_edge  = start_i && !m_sprev && m_sok;
      p_edge  = pause_i && !m_pprev && m_pok;
      g_left  = (ball_x_i < 4);
      g_right = (ball_x_i > 636);
      m_breset = 0;
      case (m_state)
        0, 5: if (s_edge) begin
          m_state = 1; m_pl = 0; m_pc = 0; m_dir = 1; m_left = SERVE_T; m_breset = 1;
        end
        1: if (tick_i) begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        2: if (g_left) begin
          if (m_pl < WIN) m_pl++;
          m_dir = 0; m_state = 3; m_left = POINT_T;
        end else if (g_right) begin
          if (m_pc < WIN) m_pc++;
          m_dir = 1; m_state = 3; m_left = POINT_T;
        end else if (p_edge) begin
          m_state = 4;
        end
        3: if (tick_i) begin
          m_left--;
          if (m_left == 0) begin
            if (m_pl == WIN || m_pc == WIN) begin
              m_state = 5; m_win = (m_pl == WIN);
            end else begin
              m_state = 1; m_left = SERVE_T; m_breset = 1;
            end
          end
        end
        4: if (p_edge) m_state = 2;
        default: m_state = 0;
      endcase
      if (!start_i) m_sok = 1;
      if (!pause_i) m_pok = 1;
      m_sprev = start_i;
      m_pprev = pause_i;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("state",        state_o,        m_state);
      check("run",          run_o,          (m_state == 2) ? 1 : 0);
      check("ball_reset",   ball_reset_o,   m_breset);
      check("serve_dir",    serve_dir_o,    m_dir);
      check("score_player", score_player_o, m_pl);
      check("score_pc",     score_pc_o,     m_pc);
      check("game_over",    game_over_o,    (m_state == 5) ? 1 : 0);
      if (m_state == 5) check("winner", winner_o, m_win);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_i = 1'b1; cyc();
      tick_i = 1'b0; cyc();
    end
  endtask

  initial begin
    // Start key held through reset must not start the match.
    start_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) cyc();
    check("held_start_idle", state_o, 0);
    check("reset_dir", serve_dir_o, 1);
    start_i = 1'b0; cyc();
    $display("[%0t] reset released with start held: state=%0d", $time, state_o);

    start_i = 1'b1; cyc();
    check("serve_entry", state_o, 1);
    check("serve_ball_reset", ball_reset_o, 1);
    start_i = 1'b0; cyc();
    check("ball_reset_one_cycle", ball_reset_o, 0);
    ticks(SERVE_T - 1);
    check("serve_before_last", state_o, 1);
    tick_i = 1'b1; cyc(); tick_i = 1'b0;
    check("play_state", state_o, 2);
    check("play_run", run_o, 1);
    $display("[%0t] serve done: state=%0d run=%0d", $time, state_o, run_o);
    cyc();

    ball_x_i = 11'd2; cyc(); ball_x_i = 11'd320;
    check("left_goal_state", state_o, 3);
    check("left_goal_score", score_player_o, 1);
    check("left_goal_dir", serve_dir_o, 0);
    check("left_goal_run", run_o, 0);
    $display("[%0t] left goal: player=%0d pc=%0d", $time, score_player_o, score_pc_o);
    ticks(POINT_T - 1);
    check("point_before_last", state_o, 3);
    tick_i = 1'b1; cyc(); tick_i = 1'b0;
    check("reserve_state", state_o, 1);
    check("reserve_ball_reset", ball_reset_o, 1);
    cyc();
    ticks(SERVE_T);

    pause_i = 1'b1; cyc();
    check("pause_state", state_o, 4);
    check("pause_run", run_o, 0);
    repeat (3) cyc();
    check("pause_held", state_o, 4);
    pause_i = 1'b0; cyc();
    pause_i = 1'b1; cyc();
    check("resume_state", state_o, 2);
    check("resume_no_reset", ball_reset_o, 0);
    check("resume_player", score_player_o, 1);
    pause_i = 1'b0; cyc();
    $display("[%0t] pause/resume: state=%0d", $time, state_o);

    ball_x_i = 11'd637; pause_i = 1'b1; cyc();
    ball_x_i = 11'd320; pause_i = 1'b0;
    check("goal_vs_pause_state", state_o, 3);
    check("goal_vs_pause_pc", score_pc_o, 1);
    $display("[%0t] right goal with pause: pc=%0d state=%0d", $time, score_pc_o, state_o);
    ticks(POINT_T);
    ticks(SERVE_T);

    for (int k = 2; k <= WIN; k++) begin
      ball_x_i = 11'd637; cyc(); ball_x_i = 11'd320;
      ticks(POINT_T);
      if (k < WIN) ticks(SERVE_T);
      $display("[%0t] right goal %0d: pc=%0d state=%0d", $time, k, score_pc_o, state_o);
    end
    check("game_over_state", state_o, 5);
    check("game_over_flag", game_over_o, 1);
    check("game_over_winner", winner_o, 0);
    check("game_over_pc", score_pc_o, 7);
    ticks(3);
    check("game_over_frozen", score_pc_o, 7);

    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("restart_state", state_o, 1);
    check("restart_pc", score_pc_o, 0);
    check("restart_player", score_player_o, 0);
    check("restart_dir", serve_dir_o, 1);
    check("restart_game_over", game_over_o, 0);
    $display("[%0t] restart: state=%0d", $time, state_o);
    cyc();
    ticks(SERVE_T);

    ball_x_i = 11'd2; cyc(); ball_x_i = 11'd320;
    ticks(POINT_T);
    ticks(SERVE_T);
    check("pre_reset_play", state_o, 2);
    check("pre_reset_player", score_player_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_state", state_o, 0);
    check("async_reset_run", run_o, 0);
    check("async_reset_player", score_player_o, 0);
    check("async_reset_pc", score_pc_o, 0);
    check("async_reset_dir", serve_dir_o, 1);
    $display("[%0t] async reset mid-play: state=%0d", $time, state_o);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) cyc();
    check("post_reset_idle", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
